// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: datapath widths, NOP encoding,
// fetch FSM states and opcode field position.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    HOLD
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register: flush beats load; load picks the fetch path or
// the instruction parked in the hold register.
module ifid_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            sel_hold,
  input  logic [XLEN-1:0] fetch_instr,
  input  logic [XLEN-1:0] fetch_pc4,
  input  logic [XLEN-1:0] hold_instr,
  input  logic [XLEN-1:0] hold_pc4,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_plus4
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= sel_hold ? hold_instr : fetch_instr;
      pc_plus4 <= sel_hold ? hold_pc4 : fetch_pc4;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: owns the PC, fetches over a req/ready handshake and feeds
// the IF/ID register, handling redirects, stalls and in-flight discards.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Stall,
  input  logic                Branch,
  input  logic [XLEN-1:0]     BranchTarget,
  input  logic                Jump,
  input  logic [XLEN-1:0]     JumpTarget,
  output logic                IMemReq,
  output logic [XLEN-1:0]     IMemAddr,
  input  logic                IMemReady,
  input  logic [XLEN-1:0]     IMemData,
  output logic                IFID_Valid,
  output logic [XLEN-1:0]     IFID_Instr,
  output logic [XLEN-1:0]     IFID_PCPlus4,
  output logic [OPCODE_W-1:0] Opcode
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_addr;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc4;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            ifid_load;
  logic            ifid_flush;
  logic            ifid_sel_hold;

  // Jump outranks Branch when both resolve in the same cycle
  assign redirect = Jump | Branch;
  assign target   = align_word(Jump ? JumpTarget : BranchTarget);
  assign pc_plus4 = pc + XLEN'(4);

  assign IMemReq  = !reset && (state != HOLD);
  assign IMemAddr = (state == DISCARD) ? pend_addr : align_word(pc);

  // IF/ID control: a cycle without a delivered instruction becomes a bubble
  always_comb begin
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_sel_hold = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          ifid_flush = 1'b1;
        end else if (!Stall) begin
          ifid_load  = IMemReady;
          ifid_flush = !IMemReady;
        end
      end
      DISCARD: ifid_flush = redirect || !Stall;
      HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
        end else if (!Stall) begin
          ifid_load     = 1'b1;
          ifid_sel_hold = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pend_addr  <= '0;
      hold_instr <= NOP_INSTR;
      hold_pc4   <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            pc <= target;
            // the old request is still in flight; keep presenting its address
            if (!IMemReady) begin
              pend_addr <= align_word(pc);
              state     <= DISCARD;
            end
          end else if (IMemReady) begin
            pc <= pc_plus4;
            if (Stall) begin
              hold_instr <= IMemData;
              hold_pc4   <= pc_plus4;
              state      <= HOLD;
            end
          end
        end
        DISCARD: begin
          if (redirect) pc <= target;
          if (IMemReady) state <= FETCH;
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (!Stall) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .sel_hold   (ifid_sel_hold),
    .fetch_instr(IMemData),
    .fetch_pc4  (pc_plus4),
    .hold_instr (hold_instr),
    .hold_pc4   (hold_pc4),
    .valid      (IFID_Valid),
    .instr      (IFID_Instr),
    .pc_plus4   (IFID_PCPlus4)
  );

  assign Opcode = IFID_Valid ? IFID_Instr[OPCODE_MSB:OPCODE_LSB] : OPCODE_W'(0);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural fetch-stream model plus a
// wait-state memory, driven by directed scenarios then random traffic.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, Stall, Branch, Jump, IMemReady;
  logic [31:0] BranchTarget, JumpTarget, IMemData, IMemAddr;
  logic        IMemReq, IFID_Valid;
  logic [31:0] IFID_Instr, IFID_PCPlus4;
  logic [5:0]  Opcode;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .Stall       (Stall),
    .Branch      (Branch),
    .BranchTarget(BranchTarget),
    .Jump        (Jump),
    .JumpTarget  (JumpTarget),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemReady   (IMemReady),
    .IMemData    (IMemData),
    .IFID_Valid  (IFID_Valid),
    .IFID_Instr  (IFID_Instr),
    .IFID_PCPlus4(IFID_PCPlus4),
    .Opcode      (Opcode)
  );

  int n_vec = 0;
  int n_bad = 0;

  // stimulus for the coming cycle
  logic        s_reset = 1'b1, s_stall = 1'b0, s_branch = 1'b0, s_jump = 1'b0;
  logic [31:0] s_btgt = '0, s_jtgt = '0;

  // memory wait-state configuration
  bit          rand_mode = 1'b0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int          slow_waits = 0;
  bit          outstanding = 1'b0;
  int          waits_left = 0;
  logic [31:0] out_addr = '0;

  // model: architectural PC, an abandoned in-flight request, a parked instruction
  logic [31:0] m_pc = RESET_PC, m_old = '0, m_buf = '0, m_buf_pc4 = '0;
  bit          m_drop = 1'b0, m_buf_full = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = NOP, m_pc4 = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rdy, input logic [31:0] data);
    logic [31:0] tgt;
    bit redir;
    redir = s_jump | s_branch;
    tgt   = (s_jump ? s_jtgt : s_btgt) & 32'hFFFF_FFFC;
    if (s_reset) begin
      m_pc = RESET_PC; m_drop = 0; m_buf_full = 0;
      m_valid = 0; m_instr = NOP; m_pc4 = '0;
    end else if (m_buf_full) begin
      if (redir) begin
        m_buf_full = 0; m_pc = tgt; m_valid = 0;
      end else if (!s_stall) begin
        m_buf_full = 0; m_valid = 1; m_instr = m_buf; m_pc4 = m_buf_pc4;
      end
    end else if (m_drop) begin
      if (rdy) m_drop = 0;
      if (redir) m_pc = tgt;
      m_valid = 0;
    end else if (redir) begin
      m_valid = 0;
      if (!rdy) begin m_drop = 1; m_old = m_pc; end
      m_pc = tgt;
    end else if (rdy) begin
      if (s_stall) begin
        m_buf_full = 1; m_buf = data; m_buf_pc4 = m_pc + 32'd4;
      end else begin
        m_valid = 1; m_instr = data; m_pc4 = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end else if (!s_stall) begin
      m_valid = 0;
    end
  endtask

  // one clock: apply inputs, compare every output, answer memory, advance model
  task automatic cycle();
    bit          exp_req, rdy;
    logic [31:0] data;
    reset = s_reset; Stall = s_stall; Branch = s_branch; Jump = s_jump;
    BranchTarget = s_btgt; JumpTarget = s_jtgt;
    IMemReady = 1'b0; IMemData = 32'hDEAD_BEEF;
    #1;
    exp_req = !s_reset && !m_buf_full;
    check("req", 32'(IMemReq), 32'(exp_req));
    if (exp_req && IMemReq) check("addr", IMemAddr, m_drop ? m_old : m_pc);
    check("valid", 32'(IFID_Valid), 32'(m_valid));
    check("instr", IFID_Instr, m_valid ? m_instr : NOP);
    if (m_valid) check("pcplus4", IFID_PCPlus4, m_pc4);
    check("opcode", 32'(Opcode), m_valid ? 32'(m_instr[31:26]) : 32'd0);
    rdy = 1'b0;
    if (IMemReq) begin
      if (!outstanding) begin
        outstanding = 1'b1;
        out_addr    = IMemAddr;
        waits_left  = rand_mode ? int'($urandom_range(0, 2))
                                : ((IMemAddr == slow_addr) ? slow_waits : 0);
      end else if (IMemAddr !== out_addr) begin
        check("addr_stable", IMemAddr, out_addr);
      end
      if (waits_left == 0) rdy = 1'b1;
      else waits_left--;
    end
    data = rdy ? mem(IMemAddr) : 32'hDEAD_BEEF;
    IMemReady = rdy; IMemData = data;
    @(posedge clk);
    model_edge(rdy, data);
    if (rdy || s_reset) outstanding = 1'b0;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // reset, then 0-wait stream 0,4 followed by a 2-wait fetch of 0x8
    slow_addr = 32'h8; slow_waits = 2;
    s_reset = 1; run(2);
    s_reset = 0; run(2);
    check("lit_instr4", IFID_Instr, 32'hFFFF_0004);
    check("lit_pc4_4", IFID_PCPlus4, 32'h0000_0008);
    run(2);
    check("lit_wait_valid", 32'(IFID_Valid), 32'd0);
    check("lit_wait_addr", IMemAddr, 32'h8);
    run(1);
    check("lit_instr8", IFID_Instr, 32'hFFFF_0008);

    // stall 3 cycles with a 0-wait fetch of 0xC
    s_stall = 1; run(3);
    check("lit_frozen", IFID_Instr, 32'hFFFF_0008);
    s_stall = 0; run(1);
    check("lit_instrC", IFID_Instr, 32'hFFFF_000C);
    check("lit_next10", IMemAddr, 32'h10);

    // jump to 0x40 during a 2-wait fetch of 0x14
    slow_addr = 32'h14; run(1);
    s_jump = 1; s_jtgt = 32'h40; run(1);
    s_jump = 0; run(2);
    check("lit_jmp_addr", IMemAddr, 32'h40);
    check("lit_jmp_flush", 32'(IFID_Valid), 32'd0);
    run(1);
    check("lit_instr40", IFID_Instr, 32'hFFFF_0040);

    // Jump and Branch together under Stall: jump wins, stall ignored
    slow_addr = 32'h80; slow_waits = 2;
    s_jump = 1; s_jtgt = 32'h80; s_branch = 1; s_btgt = 32'h100; s_stall = 1; run(1);
    s_jump = 0; s_branch = 0; s_stall = 0;
    check("lit_jb_opcode", 32'(Opcode), 32'd0);
    check("lit_jb_addr", IMemAddr, 32'h80);

    // redirect mid-wait into DISCARD, then reset while discarding
    s_branch = 1; s_btgt = 32'h200; run(1);
    s_branch = 0; run(1);
    check("lit_disc_addr", IMemAddr, 32'h80);
    s_reset = 1; run(1);
    s_reset = 0;
    check("lit_rst_addr", IMemAddr, RESET_PC);
    run(2);

    // unaligned target masked, then PC wraps past 0xFFFF_FFFC
    slow_addr = 32'hFFFF_FFFF;
    s_jump = 1; s_jtgt = 32'hFFFF_FFFF; run(1);
    s_jump = 0; run(1);
    check("lit_wrap_addr", IMemAddr, 32'h0);
    check("lit_wrap_pc4", IFID_PCPlus4, 32'h0);
    check("lit_wrap_instr", IFID_Instr, 32'h0000_FFFC);
    run(2);

    // random traffic
    rand_mode = 1;
    for (int i = 0; i < 600; i++) begin
      s_reset  = ($urandom_range(0, 99) < 2);
      s_stall  = ($urandom_range(0, 99) < 25);
      s_branch = ($urandom_range(0, 99) < 8);
      s_jump   = ($urandom_range(0, 99) < 8);
      s_btgt   = $urandom();
      s_jtgt   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255)) << 2;
      cycle();
    end
    s_reset = 0; s_stall = 0; s_branch = 0; s_jump = 0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
